ksa_scheduler: RTL
==================

KSA_SCHEDULER -- requirements
Module: ksa_scheduler

Interface
REQ-001 Parameter: KEY_BYTES, default 3, number of secret-key bytes cycled during scheduling.
REQ-002 Parameter: RAM_WIDTH, default 8, S-RAM data width.
REQ-003 Parameter: RAM_LENGTH, default 8, S-RAM address width (256 entries).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request; sampled only in IDLE.
REQ-007 secret_key  input  8*KEY_BYTES  key; byte 0 = MSB byte ([23:16] at default), byte KEY_BYTES-1 = LSB byte.
REQ-008 sOut  input  RAM_WIDTH  S-RAM read data; valid one cycle after sAddr is presented.
REQ-009 sIn  output  RAM_WIDTH  S-RAM write data.
REQ-010 sAddr  output  RAM_LENGTH  S-RAM address.
REQ-011 sWren  output  1  S-RAM write enable.
REQ-012 busy  output  1  high from the cycle after start is accepted until done.
REQ-013 done  output  1  one-cycle pulse when S holds the scheduled permutation; start trigger for the downstream decryptor.

Function
REQ-014 States: IDLE, INIT, KS_ADDR_I, KS_READ_I, KS_READ_J, KS_WRITE_I, KS_WRITE_J, DONE.
REQ-015 IDLE: sWren=0, sAddr=0, sIn=0, busy=0; start=1 latches secret_key, clears i and j, enters INIT.
REQ-016 INIT: sAddr=i, sIn=i, sWren=1, one write per cycle; i increments and wraps; after i=255 is written, go to KS_ADDR_I with i=0, j=0 (256 cycles total).
REQ-017 KS_ADDR_I: sAddr=i, sWren=0.
REQ-018 KS_READ_I: latch si=sOut; j_next = j + si + key[i mod KEY_BYTES], mod 256; register j=j_next; sAddr=j_next, sWren=0.
REQ-019 KS_READ_J: latch sj=sOut, sWren=0.
REQ-020 KS_WRITE_I: sAddr=i, sIn=sj, sWren=1.
REQ-021 KS_WRITE_J: sAddr=j, sIn=si, sWren=1; increment i (8-bit wrap); if i was 255, go to DONE, else go to KS_ADDR_I.
REQ-022 Swap phase is exactly 5 cycles per i, 1280 cycles total.
REQ-023 i==j: both writes target the same address; the final value is si, leaving the entry unchanged.
REQ-024 Key index i mod KEY_BYTES is kept as a separate counter (0..KEY_BYTES-1, wraps), reset to 0 on entering KS_ADDR_I at i=0; no divider.
REQ-025 All j, si and key additions truncate to RAM_WIDTH bits.
REQ-026 DONE: done=1 for exactly one cycle, busy=0, sWren=0; unconditionally return to IDLE.
REQ-027 Latency: start accepted at edge E0; INIT occupies cycles 1-256, swap occupies cycles 257-1536, done is high in cycle 1537.
REQ-028 start while busy or in DONE is ignored; secret_key changes after acceptance have no effect on the run.
REQ-029 sWren is high only in INIT, KS_WRITE_I and KS_WRITE_J.

Reset
REQ-030 reset=1 at an edge forces IDLE; clears i, j, si, sj, the key counter and the latched key. In the following cycle busy=0, done=0, sWren=0, sAddr=0, sIn=0.
REQ-031 reset has priority over start in the same cycle. Reset mid-run aborts with no further writes; S contents are left partially updated.

Verification
REQ-032 Reset: assert reset 2 cycles with start=1 -> busy=0, done=0, sWren=0, sAddr=0 throughout, and IDLE is held.
REQ-033 INIT: start with key 0x000000 -> 256 consecutive writes with sAddr=sIn=0..255; busy=1 throughout.
REQ-034 Early swaps, key 0x000000 -> i=0 writes S[0]=0 twice; i=1 writes S[1]=1 twice; i=2 yields j=3, so S[2]=3 and S[3]=2.
REQ-035 Full run, key 0x000249 and 0x000000 -> final 256-byte S matches a software KSA model; done pulses exactly in cycle 1537, width 1.
REQ-036 Start pulses at cycles 10 and 1537 of a run -> both ignored, no restart; a start in the cycle after done returns to IDLE and is accepted.
REQ-037 Reset asserted at cycle 700 (swap phase) -> sWren=0 from the next cycle on; a new start then gives a full 256+1280-cycle run with a correct final S.

Source files
------------

// File: rtl/ksa_scheduler.sv
// ---------------------------------------------------------------------------
// ksa_scheduler
//   RC4 key-scheduling engine that drives an external synchronous S-RAM.
//   After a start request it fills S with the identity permutation (INIT),
//   then runs the 256 key-scheduling swaps, and pulses done once S holds
//   the scheduled permutation.
//
// Ports
//   clk         : clock, all logic on the rising edge
//   reset       : synchronous, active-high reset
//   start       : single-cycle request, only looked at in IDLE
//   secret_key  : key, byte 0 is the most significant byte
//   sOut        : S-RAM read data, valid one cycle after sAddr
//   sIn         : S-RAM write data
//   sAddr       : S-RAM address
//   sWren       : S-RAM write enable
//   busy        : high while a run is in progress
//   done        : one-cycle completion pulse
// ---------------------------------------------------------------------------
module ksa_scheduler #(
  parameter int KEY_BYTES  = 3,
  parameter int RAM_WIDTH  = 8,
  parameter int RAM_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [RAM_WIDTH-1:0]   sOut,
  output logic [RAM_WIDTH-1:0]   sIn,
  output logic [RAM_LENGTH-1:0]  sAddr,
  output logic                   sWren,
  output logic                   busy,
  output logic                   done
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    KS_ADDR_I,
    KS_READ_I,
    KS_READ_J,
    KS_WRITE_I,
    KS_WRITE_J,
    DONE
  } state_t;

  state_t                 r_state;
  logic [RAM_LENGTH-1:0]  r_i;
  logic [RAM_LENGTH-1:0]  r_j;
  logic [RAM_WIDTH-1:0]   r_si;
  logic [RAM_WIDTH-1:0]   r_sj;
  logic [KIDX_W-1:0]      r_kidx;
  logic [8*KEY_BYTES-1:0] r_key;

  logic [7:0]             w_key_byte;
  logic [RAM_WIDTH-1:0]   w_j_sum;
  logic [RAM_LENGTH-1:0]  w_j_next;
  logic                   w_i_last;
  logic [KIDX_W-1:0]      w_kidx_next;

  // Key byte selected by the running key counter (i mod KEY_BYTES without
  // a divider). Byte 0 sits in the top bits of the key word.
  // NOTE: every combinational output gets a default before the selection
  // logic, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (r_kidx == KIDX_W'(k)) begin
        w_key_byte = r_key[8*(KEY_BYTES-1-k) +: 8];
      end
    end
  end

  // j + S[i] + key byte, truncated to the RAM data width. sOut carries S[i]
  // in KS_READ_I, so the new j goes straight out on sAddr in that cycle.
  assign w_j_sum     = RAM_WIDTH'(r_j) + sOut + RAM_WIDTH'(w_key_byte);
  assign w_j_next    = RAM_LENGTH'(w_j_sum);
  assign w_i_last    = (r_i == '1);
  assign w_kidx_next = (r_kidx == KIDX_W'(KEY_BYTES - 1)) ? '0
                                                          : r_kidx + KIDX_W'(1);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of code order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_si    <= '0;
      r_sj    <= '0;
      r_kidx  <= '0;
      r_key   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_key   <= secret_key;
            r_i     <= '0;
            r_j     <= '0;
            r_kidx  <= '0;
            r_state <= INIT;
          end
        end
        INIT: begin
          // i wraps back to 0 after the last identity write.
          r_i <= r_i + RAM_LENGTH'(1);
          if (w_i_last) begin
            r_j     <= '0;
            r_kidx  <= '0;
            r_state <= KS_ADDR_I;
          end
        end
        KS_ADDR_I: r_state <= KS_READ_I;
        KS_READ_I: begin
          r_si    <= sOut;
          r_j     <= w_j_next;
          r_state <= KS_READ_J;
        end
        KS_READ_J: begin
          r_sj    <= sOut;
          r_state <= KS_WRITE_I;
        end
        KS_WRITE_I: r_state <= KS_WRITE_J;
        KS_WRITE_J: begin
          r_i    <= r_i + RAM_LENGTH'(1);
          r_kidx <= w_kidx_next;
          r_state <= w_i_last ? DONE : KS_ADDR_I;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM-side outputs decode directly from the registered state. When i == j
  // the S[j] write comes last and carries si, so the entry is unchanged.
  always_comb begin
    sAddr = '0;
    sIn   = '0;
    sWren = 1'b0;
    case (r_state)
      INIT: begin
        sAddr = r_i;
        sIn   = RAM_WIDTH'(r_i);
        sWren = 1'b1;
      end
      KS_ADDR_I: sAddr = r_i;
      KS_READ_I: sAddr = w_j_next;
      KS_READ_J: sAddr = r_j;
      KS_WRITE_I: begin
        sAddr = r_i;
        sIn   = r_sj;
        sWren = 1'b1;
      end
      KS_WRITE_J: begin
        sAddr = r_j;
        sIn   = r_si;
        sWren = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (r_state != IDLE) && (r_state != DONE);
  assign done = (r_state == DONE);

endmodule
